muldiv_engine: RTL
==================

# muldiv_engine

Parametrised multi-cycle multiply/divide unit with HI/LO register pair for the pipelined MIPS core's execute stage. It generalises the fixed 32-bit unit: configurable operand width and per-class latency, plus aborting flush on interrupt and optional multiply-accumulate. The execute stage drives operands and the op code. It stalls issue of any HI/LO-touching instruction while `busy` is high, and muxes `hi`/`lo` onto its result bus for mfhi/mflo.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥ 8).
- `MULT_CYCLES`, 5, busy cycles for multiply-class ops (≥ 1).
- `DIV_CYCLES`, 10, busy cycles for divide ops (≥ 1).

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: abort in-flight op (driven by the interrupt request).
- `start` in 1: issue `op` this cycle.
- `op` in 4: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others are no-ops.
- `d1` in WIDTH: rs operand (forwarded).
- `d2` in WIDTH: rt operand (forwarded).
- `busy` out 1: operation in flight.
- `hi` out WIDTH: committed HI.
- `lo` out WIDTH: committed LO.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, counter=0, pending result cleared.
- States: IDLE, RUN.
- **IDLE, `start` with op 1–4 (or 7–10 when enabled), `flush`=0:**
  - compute the result from `d1`/`d2` (and current `hi`/`lo` for accumulate);
  - latch it into a 2·WIDTH pending register;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- **RUN:** decrement the counter each cycle. When the counter reaches 1, commit pending to `hi`/`lo` at that edge and return to IDLE.
- **MTHI/MTLO:** accepted in IDLE only. Writes `d1` to `hi`/`lo` at the same edge; `busy` never asserts.
- **Arithmetic:**
  - MULT/MULTU: signed/unsigned WIDTH×WIDTH→2·WIDTH product; HI = upper half, LO = lower half.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
  - Divisor 0: `hi`/`lo` left unchanged. Full DIV_CYCLES busy period still runs.
  - Most-negative ÷ −1: LO = most-negative value, HI = 0.
- **Boundary behaviour:**
  - `start` while RUN: ignored, no queueing. This includes MTHI/MTLO.
  - `flush` in RUN: return to IDLE at that edge; `hi`/`lo` keep pre-op values; pending discarded.
  - `flush` together with `start` in IDLE: start ignored; MTHI/MTLO also suppressed.
  - `reset` has priority over `flush` and `start`, and aborts RUN.
  - Undefined op codes with `start`: no state change.

## Timing
- `start` accepted at edge t: `busy`=1 from t+1 through t+N (N = MULT_CYCLES or DIV_CYCLES).
- `hi`/`lo` take the new value at edge t+N, visible in cycle t+N+1; `busy`=0 in cycle t+N+1.
- A new `start` is accepted in cycle t+N+1, i.e. back-to-back with one idle-visible cycle.
- MTHI/MTLO: value visible the cycle after the edge; 0 busy cycles.
- `flush` at edge f during RUN: `busy`=0 in cycle f+1.
- `busy`, `hi` and `lo` are registered outputs with no combinational path from inputs.

## Configuration
- `MULDIV_MADD_EN` defined: ops 7–10 are implemented with MULT_CYCLES latency.
  - MADD/MADDU: {HI,LO} ← {HI,LO} + product.
  - MSUB/MSUBU: {HI,LO} ← {HI,LO} − product.
  - Arithmetic is modulo 2^(2·WIDTH); signedness of the product follows the op.
- Not defined: ops 7–10 are undefined codes and are ignored; the accumulate datapath is not synthesised.

## Test plan
- MULT `d1`=0xFFFFFFFD, `d2`=7 → `busy` high exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIVU 100/7 → `lo`=14, `hi`=2 after 10 busy cycles. DIV 0xFFFFFFF9 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Preload `hi`=0x11, `lo`=0x22 via MTHI/MTLO. Then:
  - DIV 5/0 → 10 busy cycles, `hi`/`lo` still 0x11/0x22;
  - MULT 3×4 with `flush` on the 3rd busy cycle → `busy`=0 next cycle, `hi`/`lo` still 0x11/0x22.
- MTHI 0x1234 in IDLE → `hi`=0x1234 next cycle, `busy` stays 0. MTLO 0x55 issued during RUN of a MULTU 2×3 → ignored; final `lo`=6.
- `reset` asserted mid-DIVU → next cycle `busy`=0, `hi`=`lo`=0. `start` with op 15 → no change.
- With `MULDIV_MADD_EN`, `hi`=0, `lo`=0xFFFFFFFF, MADDU 1×1 → `hi`=1, `lo`=0. Then MSUB 1×2 → `hi`=0, `lo`=0xFFFFFFFE. Without the macro, the same sequence leaves `hi`/`lo` unchanged and `busy`=0.

Source files
------------

// File: rtl/muldiv_engine.sv
// muldiv_engine
//   Multi-cycle multiply/divide unit with a HI/LO register pair for the
//   execute stage. An accepted arithmetic op computes its result at once
//   into a pending register. The result is committed to hi/lo after
//   MULT_CYCLES or DIV_CYCLES busy cycles. A flush during RUN discards the
//   pending result.
//
//   Optional feature: define MULDIV_MADD_EN to implement MADD/MADDU/MSUB/MSUBU
//   (ops 7-10). These ops accumulate into {hi,lo}. When the macro is not
//   defined, those codes are ignored like any other undefined op.
//
//   Handshake: an op is taken when start=1, flush=0 and the unit is idle
//   (busy=0). There is no queue. A start seen while busy is dropped, and the
//   issuing stage must hold HI/LO users until busy falls.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (priority over all)
//   flush    in   abort in-flight op / suppress issue this cycle
//   start    in   issue op this cycle
//   op       in   [3:0] operation code
//   d1, d2   in   [WIDTH-1:0] rs / rt operands
//   busy     out  operation in flight (registered)
//   hi, lo   out  [WIDTH-1:0] committed HI/LO (registered)
//   dbgState out  FSM state, 0 = IDLE, 1 = RUN

module muldiv_engine #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbgState
);

    localparam int W2         = 2 * WIDTH;
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateE;

    stateE          state;
    logic [CW-1:0]  counter;
    logic [W2-1:0]  pending;
    logic           pendingWrite;   // cleared for divide-by-zero: hi/lo stay put

    // Combinational datapath
    logic [W2-1:0]    prodS, prodU, pendNext;
    logic [WIDTH-1:0] absA, absB, safeDivU, safeDivS;
    logic [WIDTH-1:0] quotU, remU, quotMag, remMag, quotS, remS;
    logic             opAccept, writeNext;
    logic [CW-1:0]    opCycles;

    always_comb begin
        prodS = $signed({{WIDTH{d1[WIDTH-1]}}, d1}) * $signed({{WIDTH{d2[WIDTH-1]}}, d2});
        prodU = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};

        // Signed divide done on magnitudes. The most-negative value is its
        // own magnitude as unsigned, so MIN / -1 folds back to MIN with rem 0.
        absA     = d1[WIDTH-1] ? (~d1 + WIDTH'(1)) : d1;
        absB     = d2[WIDTH-1] ? (~d2 + WIDTH'(1)) : d2;
        // A zero divisor is replaced by 1 so the divider never sees 0. Its
        // result is not committed.
        safeDivU = (d2 == '0) ? WIDTH'(1) : d2;
        safeDivS = (d2 == '0) ? WIDTH'(1) : absB;
        quotU    = d1 / safeDivU;
        remU     = d1 % safeDivU;
        quotMag  = absA / safeDivS;
        remMag   = absA % safeDivS;
        quotS    = (d1[WIDTH-1] ^ d2[WIDTH-1]) ? (~quotMag + WIDTH'(1)) : quotMag;
        remS     = d1[WIDTH-1] ? (~remMag + WIDTH'(1)) : remMag;

        opAccept  = 1'b0;
        opCycles  = '0;
        pendNext  = {hi, lo};
        writeNext = 1'b1;
        case (op)
            OP_MULT:  begin opAccept = 1'b1; opCycles = CW'(MULT_CYCLES); pendNext = prodS; end
            OP_MULTU: begin opAccept = 1'b1; opCycles = CW'(MULT_CYCLES); pendNext = prodU; end
            OP_DIV: begin
                opAccept  = 1'b1;
                opCycles  = CW'(DIV_CYCLES);
                pendNext  = {remS, quotS};
                writeNext = (d2 != '0);
            end
            OP_DIVU: begin
                opAccept  = 1'b1;
                opCycles  = CW'(DIV_CYCLES);
                pendNext  = {remU, quotU};
                writeNext = (d2 != '0);
            end
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin opAccept = 1'b1; opCycles = CW'(MULT_CYCLES); pendNext = {hi, lo} + prodS; end
            OP_MADDU: begin opAccept = 1'b1; opCycles = CW'(MULT_CYCLES); pendNext = {hi, lo} + prodU; end
            OP_MSUB:  begin opAccept = 1'b1; opCycles = CW'(MULT_CYCLES); pendNext = {hi, lo} - prodS; end
            OP_MSUBU: begin opAccept = 1'b1; opCycles = CW'(MULT_CYCLES); pendNext = {hi, lo} - prodU; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            counter      <= '0;
            pending      <= '0;
            pendingWrite <= 1'b0;
        end else if (state == IDLE) begin
            if (start && !flush) begin
                if (opAccept) begin
                    pending      <= pendNext;
                    pendingWrite <= writeNext;
                    counter      <= opCycles;
                    state        <= RUN;
                    busy         <= 1'b1;
                end else if (op == OP_MTHI) begin
                    hi <= d1;
                end else if (op == OP_MTLO) begin
                    lo <= d1;
                end
            end
        end else begin
            // RUN: flush wins even on the commit edge.
            if (flush) begin
                state        <= IDLE;
                busy         <= 1'b0;
                counter      <= '0;
                pending      <= '0;
                pendingWrite <= 1'b0;
            end else if (counter == CW'(1)) begin
                if (pendingWrite) begin
                    {hi, lo} <= pending;
                end
                state   <= IDLE;
                busy    <= 1'b0;
                counter <= '0;
            end else begin
                counter <= counter - CW'(1);
            end
        end
    end

    assign dbgState = (state == RUN);

endmodule
